apu_pulse_bank: RTL and testbench
=================================

# apu_pulse_bank

Parametrised bank of NES-style pulse (square-wave) channels with a per-channel configuration port and a single ready/valid sample stream. Each beat of the stream carries one output bit per channel and a mixed amplitude. The consumer's `out_rdy` paces the bank: one accepted beat advances every channel by one timer tick. The bank sits between the register/config front end and the audio DAC/PWM stage, and replaces separately instantiated single-channel pulse generators.

## Interface
Parameters:
- `NUM_CH`, default 3: number of pulse channels, range 1..8.
- `PERIOD_W`, default 11: timer period width.
- `CH_W`, derived, `$clog2(NUM_CH)` with a minimum of 1: channel-select width.
- `MIX_W`, derived: `$clog2(NUM_CH*15+1)` with `APU_PULSE_VOLUME_EN`, `$clog2(NUM_CH+1)` without it.

Ports:
- `clk`  in  1  the only clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cfg_ch`  in  CH_W  target channel of a config write.
- `cfg_period`  in  PERIOD_W  new timer period.
- `cfg_duty`  in  2  duty select, 0..3.
- `cfg_restart`  in  1  on write: reset the sequencer step to 0.
- `cfg_vol`  in  4  channel volume; present only with `APU_PULSE_VOLUME_EN`.
- `cfg_vld`  in  1  config write valid.
- `cfg_rdy`  out  1  config ready.
- `out_bits`  out  NUM_CH  per-channel pulse bit.
- `out_mix`  out  MIX_W  mixed amplitude.
- `out_vld`  out  1  sample valid.
- `out_rdy`  in  1  sample ready.

## Operation
- Per-channel state:
  - `period` [PERIOD_W]
  - `duty` [2]
  - `timer` [PERIOD_W]
  - `step` [3]
  - `vol` [4], macro only
- Reset values: all state 0, `out_bits` = 0, `out_mix` = 0, `out_vld` = 0, `cfg_rdy` = 0.
- `cfg_rdy` and `out_vld` are registered. Both go to 1 on the first clock edge after `rst_n` deasserts and then stay at 1.
- Config write (`cfg_vld & cfg_rdy`):
  - The channel `cfg_ch` loads `period`, `duty` and `vol`, and sets `timer` = `cfg_period`.
  - If `cfg_restart` = 1, `step` is set to 0; otherwise `step` is kept.
  - If `cfg_ch` >= `NUM_CH`, the write is accepted and dropped.
- Tick (`out_vld & out_rdy`), applied to every channel:
  - If `timer` == 0: `timer` <= `period` and `step` <= `step`+1, wrapping 7 -> 0.
  - Otherwise `timer` <= `timer`-1.
  - The sequencer therefore steps every `period`+1 ticks.
- Duty table, listed step 0..7:
  - duty 0: 0 1 0 0 0 0 0 0
  - duty 1: 0 1 1 0 0 0 0 0
  - duty 2: 0 1 1 1 1 0 0 0
  - duty 3: 1 0 0 1 1 1 1 1
- Channel bit = `table[duty][step]`, forced to 0 when `period` < 8 (mute).
- `out_mix`:
  - Without the macro: popcount of the channel bits.
  - With the macro: sum of `vol` over the channels whose bit is 1.
  - Zero-extended to `MIX_W`; it cannot overflow.
- Simultaneous write and tick on the same channel: the write wins for that channel, and that channel's tick is discarded. Other channels tick normally.

## Timing
- The output register (`out_bits`, `out_mix`) loads only on a tick. It captures the sample computed from the channel state before that tick's advance.
- While `out_vld & !out_rdy`, the outputs are held stable. Config writes in that window change channel state but not the presented beat.
- The first accepted beat after reset carries the reset value 0.
- Latency: a write accepted in cycle t, followed by `out_rdy` held at 1, is sampled by the tick in cycle t+1. The resulting beat appears on the outputs from cycle t+2.
- Reset mid-operation: all state clears at once (asynchronous). No partial beat is produced.
- `out_rdy` = 0 freezes every timer and sequencer indefinitely. This is not an error condition.

## Configuration
- `APU_PULSE_VOLUME_EN` defined:
  - `cfg_vol` port exists and each channel has a `vol` register.
  - `out_mix` is the volume-weighted sum, with `MIX_W` = `$clog2(NUM_CH*15+1)`.
- `APU_PULSE_VOLUME_EN` not defined:
  - No `cfg_vol` port and no `vol` registers.
  - `out_mix` is the count of high channels.
- All other behaviour is identical in both builds.

## Structure
- Package `apu_pkg` holds:
  - `duty_t` (2-bit) typedef.
  - 4x8 `DUTY_TABLE` constant.
  - `MIN_PERIOD` = 8.
  - `SEQ_STEPS` = 8.
- Sub-module `apu_pulse_channel` holds one channel's registers, the write/tick priority logic and the bit output.
- The top level holds:
  - `NUM_CH` generate instances of `apu_pulse_channel`.
  - Write decode.
  - Mixer.
  - Output register.
  - The `cfg_rdy`/`out_vld` registers.

## Test plan
- Reset:
  - Hold `rst_n` = 0 and toggle `clk` -> all outputs are 0.
  - Release `rst_n` -> `cfg_rdy` and `out_vld` are 1 on the next edge, and the first beat has `out_bits` = 0.
- Basic waveform:
  - Write ch0 with period 8, duty 2, restart; then hold `out_rdy` = 1.
  - -> Starting at cycle t+2, bit0 reads 0 for 9 beats, 1 for 36, then 0 for 27; the 72-beat period repeats.
- Mute:
  - Write ch1 with period 7, duty 3.
  - -> bit1 stays 0 for 200 beats. Then write period 100 -> bit1 toggles per the duty-3 pattern.
- Backpressure:
  - Drop `out_rdy` for 50 cycles mid-waveform.
  - -> The outputs hold and the waveform resumes without phase loss; total high beats are unchanged versus a no-stall run.
- Collision and out-of-range channel:
  - Issue a write to ch2 in a tick cycle where ch2's timer is 0.
  - -> ch2's `timer` equals the new period and `step` is unchanged when `cfg_restart` = 0.
  - Write with `cfg_ch` = 3 when `NUM_CH` = 3 -> accepted, and no state changes.
- Mixer:
  - Set all three channels to duty 3, period 8, restart.
  - -> Without the macro, `out_mix` = 3 on step-0 beats.
  - -> With the macro and vol = 15, 7, 1, `out_mix` = 23.

Source files
------------

// File: rtl/apu_pkg.sv
// -----------------------------------------------------------------------------
// apu_pkg
// Shared definitions for the pulse-channel bank: the duty-select type, the
// 4x8 duty waveform table (bit index = sequencer step), the mute threshold on
// the timer period and the sequencer length.
// -----------------------------------------------------------------------------
package apu_pkg;

    typedef logic [1:0] duty_t;

    localparam int SEQ_STEPS  = 8;
    localparam int STEP_W     = $clog2(SEQ_STEPS);
    localparam int MIN_PERIOD = 8;

    // Row = duty select, bit n of a row = output level at sequencer step n.
    //   duty 0: 0 1 0 0 0 0 0 0
    //   duty 1: 0 1 1 0 0 0 0 0
    //   duty 2: 0 1 1 1 1 0 0 0
    //   duty 3: 1 0 0 1 1 1 1 1
    localparam logic [3:0][SEQ_STEPS-1:0] DUTY_TABLE = {
        8'b1111_1001,   // duty 3
        8'b0001_1110,   // duty 2
        8'b0000_0110,   // duty 1
        8'b0000_0010    // duty 0
    };

    // Waveform level for a given duty select and sequencer step.
    function automatic logic duty_bit(input duty_t duty, input logic [STEP_W-1:0] step);
        return DUTY_TABLE[duty][step];
    endfunction

endpackage

// File: rtl/apu_pulse_channel.sv
// -----------------------------------------------------------------------------
// apu_pulse_channel
// One NES-style pulse channel: period/duty (and optional volume) registers,
// a down-counting timer that clocks an 8-step duty sequencer once per
// period+1 ticks, and the resulting pulse bit (muted when period < 8).
// A config write on the same cycle as a tick wins; that tick is discarded.
//
// Optional feature macro: APU_PULSE_VOLUME_EN (adds wr_vol / vol).
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   wr_en        load this channel's configuration this cycle
//   wr_period    new timer period (also reloads the timer)
//   wr_duty      new duty select
//   wr_restart   on write, return the sequencer to step 0
//   wr_vol       new volume (macro build only)
//   tick         advance timer/sequencer by one tick
//   pulse_bit    current channel output level
//   vol          current volume register (macro build only)
// -----------------------------------------------------------------------------
module apu_pulse_channel
    import apu_pkg::*;
#(
    parameter int PERIOD_W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [PERIOD_W-1:0] wr_period,
    input  duty_t               wr_duty,
    input  logic                wr_restart,
`ifdef APU_PULSE_VOLUME_EN
    input  logic [3:0]          wr_vol,
    output logic [3:0]          vol,
`endif
    input  logic                tick,
    output logic                pulse_bit
);

    logic [PERIOD_W-1:0] period_r;
    duty_t               duty_r;
    logic [PERIOD_W-1:0] timer_r;
    logic [STEP_W-1:0]   step_r;
    logic                mute_s;
`ifdef APU_PULSE_VOLUME_EN
    logic [3:0]          vol_r;
`endif

    // Channel state: a write takes priority over a tick in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_r <= {PERIOD_W{1'b0}};
            duty_r   <= 2'b00;
            timer_r  <= {PERIOD_W{1'b0}};
            step_r   <= {STEP_W{1'b0}};
`ifdef APU_PULSE_VOLUME_EN
            vol_r    <= 4'd0;
`endif
        end else if (wr_en) begin
            period_r <= wr_period;
            duty_r   <= wr_duty;
            timer_r  <= wr_period;
            if (wr_restart) begin
                step_r <= {STEP_W{1'b0}};
            end else begin
                step_r <= step_r;
            end
`ifdef APU_PULSE_VOLUME_EN
            vol_r    <= wr_vol;
`endif
        end else if (tick) begin
            if (timer_r == {PERIOD_W{1'b0}}) begin
                timer_r <= period_r;
                step_r  <= step_r + {{(STEP_W-1){1'b0}}, 1'b1};   // wraps 7 -> 0
            end else begin
                timer_r <= timer_r - {{(PERIOD_W-1){1'b0}}, 1'b1};
                step_r  <= step_r;
            end
        end else begin
            timer_r <= timer_r;
            step_r  <= step_r;
        end
    end

    // Output level: duty table lookup, forced low for ultrasonic periods.
    always_comb begin
        mute_s = (period_r < PERIOD_W'(MIN_PERIOD));
        if (mute_s) begin
            pulse_bit = 1'b0;
        end else begin
            pulse_bit = duty_bit(duty_r, step_r);
        end
    end

`ifdef APU_PULSE_VOLUME_EN
    assign vol = vol_r;
`endif

endmodule

// File: rtl/apu_pulse_bank.sv
// -----------------------------------------------------------------------------
// apu_pulse_bank
// Bank of NUM_CH pulse channels sharing one config port and one ready/valid
// sample stream. Each accepted beat (out_vld & out_rdy) ticks every channel
// once and registers the sample computed from the pre-tick channel state:
// one bit per channel plus a mixed amplitude (popcount of high channels, or
// with APU_PULSE_VOLUME_EN the sum of their volumes).
//
// Optional feature macro: APU_PULSE_VOLUME_EN (cfg_vol port, per-channel
// volume, volume-weighted mix).
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   cfg_ch        target channel (writes to cfg_ch >= NUM_CH are dropped)
//   cfg_period    timer period
//   cfg_duty      duty select
//   cfg_restart   reset the sequencer step on write
//   cfg_vol       channel volume (macro build only)
//   cfg_vld/rdy   config handshake
//   out_bits      per-channel pulse bits of the current beat
//   out_mix       mixed amplitude of the current beat
//   out_vld/rdy   sample stream handshake
// -----------------------------------------------------------------------------
module apu_pulse_bank
    import apu_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int PERIOD_W = 11,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
`ifdef APU_PULSE_VOLUME_EN
    parameter int MIX_W    = $clog2(NUM_CH * 15 + 1)
`else
    parameter int MIX_W    = $clog2(NUM_CH + 1)
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [1:0]          cfg_duty,
    input  logic                cfg_restart,
`ifdef APU_PULSE_VOLUME_EN
    input  logic [3:0]          cfg_vol,
`endif
    input  logic                cfg_vld,
    output logic                cfg_rdy,
    output logic [NUM_CH-1:0]   out_bits,
    output logic [MIX_W-1:0]    out_mix,
    output logic                out_vld,
    input  logic                out_rdy
);

    logic                cfg_rdy_r;
    logic                out_vld_r;
    logic [NUM_CH-1:0]   out_bits_r;
    logic [MIX_W-1:0]    out_mix_r;

    logic                cfg_fire_s;
    logic                tick_s;
    logic [NUM_CH-1:0]   wr_en_s;
    logic [NUM_CH-1:0]   ch_bit_s;
    logic [MIX_W-1:0]    mix_s;
`ifdef APU_PULSE_VOLUME_EN
    logic [3:0]          ch_vol_s [NUM_CH];
`endif

    assign cfg_fire_s = cfg_vld & cfg_rdy_r;
    assign tick_s     = out_vld_r & out_rdy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Write decode: an out-of-range cfg_ch matches no channel and is dropped.
        assign wr_en_s[i] = cfg_fire_s & (cfg_ch == CH_W'(i));

        apu_pulse_channel #(
            .PERIOD_W   (PERIOD_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (wr_en_s[i]),
            .wr_period  (cfg_period),
            .wr_duty    (cfg_duty),
            .wr_restart (cfg_restart),
`ifdef APU_PULSE_VOLUME_EN
            .wr_vol     (cfg_vol),
            .vol        (ch_vol_s[i]),
`endif
            .tick       (tick_s),
            .pulse_bit  (ch_bit_s[i])
        );
    end

    // Mixer: popcount of high channels, or their summed volume.
    always_comb begin
        mix_s = {MIX_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_bit_s[i]) begin
`ifdef APU_PULSE_VOLUME_EN
                mix_s = mix_s + MIX_W'(ch_vol_s[i]);
`else
                mix_s = mix_s + {{(MIX_W-1){1'b0}}, 1'b1};
`endif
            end else begin
                mix_s = mix_s;
            end
        end
    end

    // Handshake flags: both rise on the first edge out of reset and stay high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rdy_r <= 1'b0;
            out_vld_r <= 1'b0;
        end else begin
            cfg_rdy_r <= 1'b1;
            out_vld_r <= 1'b1;
        end
    end

    // Beat register: loads the pre-tick sample only when the beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bits_r <= {NUM_CH{1'b0}};
            out_mix_r  <= {MIX_W{1'b0}};
        end else if (tick_s) begin
            out_bits_r <= ch_bit_s;
            out_mix_r  <= mix_s;
        end else begin
            out_bits_r <= out_bits_r;
            out_mix_r  <= out_mix_r;
        end
    end

    assign cfg_rdy  = cfg_rdy_r;
    assign out_vld  = out_vld_r;
    assign out_bits = out_bits_r;
    assign out_mix  = out_mix_r;

endmodule

// File: tb/tb_apu_pulse_bank.sv
// -----------------------------------------------------------------------------
// tb_apu_pulse_bank
// Directed bench for apu_pulse_bank (NUM_CH = 3, PERIOD_W = 11). A behavioural
// channel model predicts each beat when the tick is issued; predictions are
// queued and compared when the beat reaches the outputs.
// -----------------------------------------------------------------------------
module tb_apu_pulse_bank;

    localparam int NUM_CH   = 3;
    localparam int PERIOD_W = 11;
    localparam int CH_W     = 2;
`ifdef APU_PULSE_VOLUME_EN
    localparam int MIX_W    = 6;
    localparam int MIX_ALL  = 23;   // vol 15 + 7 + 1
`else
    localparam int MIX_W    = 2;
    localparam int MIX_ALL  = 3;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [CH_W-1:0]     cfg_ch;
    logic [PERIOD_W-1:0] cfg_period;
    logic [1:0]          cfg_duty;
    logic                cfg_restart;
    logic [3:0]          cfg_vol;
    logic                cfg_vld;
    logic                cfg_rdy;
    logic [NUM_CH-1:0]   out_bits;
    logic [MIX_W-1:0]    out_mix;
    logic                out_vld;
    logic                out_rdy;

    apu_pulse_bank #(
        .NUM_CH      (NUM_CH),
        .PERIOD_W    (PERIOD_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_restart (cfg_restart),
`ifdef APU_PULSE_VOLUME_EN
        .cfg_vol     (cfg_vol),
`endif
        .cfg_vld     (cfg_vld),
        .cfg_rdy     (cfg_rdy),
        .out_bits    (out_bits),
        .out_mix     (out_mix),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] bits;
        logic [MIX_W-1:0]  mix;
    } beat_t;

    beat_t sb_q[$];
    beat_t last_exp;

    int n_cmp  = 0;
    int n_fail = 0;
    int hi_cnt [NUM_CH];

    // channel model
    int m_period [NUM_CH];
    int m_duty   [NUM_CH];
    int m_timer  [NUM_CH];
    int m_step   [NUM_CH];
    int m_vol    [NUM_CH];
    bit m_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference duty waveforms written as step ranges.
    function automatic bit ref_level(input int duty, input int step);
        case (duty)
            0:       return (step == 1);
            1:       return (step == 1 || step == 2);
            2:       return (step >= 1 && step <= 4);
            default: return !(step == 1 || step == 2);
        endcase
    endfunction

    function automatic beat_t model_beat();
        beat_t b;
        int    mix;
        mix    = 0;
        b.bits = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_period[c] >= 8 && ref_level(m_duty[c], m_step[c])) begin
                b.bits[c] = 1'b1;
`ifdef APU_PULSE_VOLUME_EN
                mix += m_vol[c];
`else
                mix += 1;
`endif
            end
        end
        b.mix = MIX_W'(mix);
        return b;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_period[c] = 0; m_duty[c] = 0; m_timer[c] = 0; m_step[c] = 0; m_vol[c] = 0;
        end
        m_vld = 1'b0;
        last_exp.bits = '0;
        last_exp.mix  = '0;
    endtask

    // One clock: predict, advance the model, clock the DUT, compare.
    task automatic step_clk();
        bit    tick;
        bit    wr;
        bit    nvld;
        beat_t b;
        tick = m_vld && out_rdy;
        wr   = m_vld && cfg_vld;
        nvld = rst_n;
        if (tick) sb_q.push_back(model_beat());
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr && int'(cfg_ch) == c) begin
                m_period[c] = cfg_period;
                m_duty[c]   = cfg_duty;
                m_timer[c]  = cfg_period;
                m_vol[c]    = cfg_vol;
                if (cfg_restart) m_step[c] = 0;
            end else if (tick) begin
                if (m_timer[c] == 0) begin
                    m_timer[c] = m_period[c];
                    m_step[c]  = (m_step[c] + 1) % 8;
                end else begin
                    m_timer[c] = m_timer[c] - 1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (tick) begin
            b = sb_q.pop_front();
            chk("beat_bits", 32'(out_bits), 32'(b.bits));
            chk("beat_mix",  32'(out_mix),  32'(b.mix));
            last_exp = b;
            for (int c = 0; c < NUM_CH; c++) hi_cnt[c] += int'(out_bits[c]);
        end else if (m_vld) begin
            chk("hold_bits", 32'(out_bits), 32'(last_exp.bits));
            chk("hold_mix",  32'(out_mix),  32'(last_exp.mix));
        end
        m_vld = nvld;
        chk("out_vld", 32'(out_vld), 32'(m_vld));
        chk("cfg_rdy", 32'(cfg_rdy), 32'(m_vld));
    endtask

    task automatic cfg_write(input int ch, input int period, input int duty,
                             input bit restart, input int vol);
        cfg_ch      = CH_W'(ch);
        cfg_period  = PERIOD_W'(period);
        cfg_duty    = 2'(duty);
        cfg_restart = restart;
        cfg_vol     = 4'(vol);
        cfg_vld     = 1'b1;
        step_clk();
        cfg_vld     = 1'b0;
        cfg_restart = 1'b0;
    endtask

    task automatic clear_hi();
        for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int old_step;
        rst_n = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_duty = '0; cfg_restart = 1'b0;
        cfg_vol = '0; cfg_vld = 1'b0; out_rdy = 1'b0;
        model_reset();
        clear_hi();

        // Reset held with clock running: everything low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld",  32'(out_vld),  32'd0);
        chk("rst_cfg_rdy",  32'(cfg_rdy),  32'd0);
        chk("rst_out_bits", 32'(out_bits), 32'd0);
        chk("rst_out_mix",  32'(out_mix),  32'd0);

        // Release: flags rise on the next edge, first beat carries zeros.
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        step_clk();
        step_clk();
        chk("first_beat", 32'(out_bits), 32'd0);

        // Basic waveform: period 8, duty 2 -> 9 low, 36 high, 27 low.
        cfg_write(0, 8, 2, 1'b1, 15);
        clear_hi();
        repeat (9) step_clk();
        chk("wave_low9", 32'(hi_cnt[0]), 32'd0);
        repeat (36) step_clk();
        chk("wave_high36", 32'(hi_cnt[0]), 32'd36);
        repeat (27) step_clk();
        chk("wave_period72", 32'(hi_cnt[0]), 32'd36);

        // Mute: period 7 never sounds; period 100 restarts duty 3.
        cfg_write(1, 7, 3, 1'b1, 7);
        clear_hi();
        repeat (200) step_clk();
        chk("mute_200", 32'(hi_cnt[1]), 32'd0);
        cfg_write(1, 100, 3, 1'b1, 7);
        clear_hi();
        repeat (300) step_clk();
        chk("unmute_300", 32'(hi_cnt[1]), 32'd101);

        // Backpressure: 50-cycle stall inside a 72-beat window of ch0.
        clear_hi();
        repeat (20) step_clk();
        out_rdy = 1'b0;
        repeat (25) step_clk();
        cfg_write(1, 50, 1, 1'b0, 3);
        repeat (24) step_clk();
        out_rdy = 1'b1;
        repeat (52) step_clk();
        chk("stall_high36", 32'(hi_cnt[0]), 32'd36);

        // Collision: write ch2 (no restart) on a tick where its timer is 0.
        cfg_write(2, 8, 1, 1'b1, 1);
        for (int k = 0; k < 20 && m_timer[2] != 0; k++) step_clk();
        chk("coll_timer0_found", 32'(m_timer[2] == 0), 32'd1);
        old_step = m_step[2];
        cfg_write(2, 20, 1, 1'b0, 1);
        chk("coll_timer", 32'(dut.g_ch[2].u_ch.timer_r), 32'd20);
        chk("coll_step",  32'(dut.g_ch[2].u_ch.step_r),  32'(old_step));

        // Out-of-range channel: accepted, nothing changes.
        out_rdy = 1'b0;
        step_clk();
        cfg_write(3, 9, 3, 1'b1, 15);
        chk("oor_rdy", 32'(cfg_rdy), 32'd1);
        chk("oor_p0", 32'(dut.g_ch[0].u_ch.period_r), 32'(m_period[0]));
        chk("oor_p1", 32'(dut.g_ch[1].u_ch.period_r), 32'(m_period[1]));
        chk("oor_p2", 32'(dut.g_ch[2].u_ch.period_r), 32'(m_period[2]));
        chk("oor_t0", 32'(dut.g_ch[0].u_ch.timer_r),  32'(m_timer[0]));
        chk("oor_t1", 32'(dut.g_ch[1].u_ch.timer_r),  32'(m_timer[1]));
        chk("oor_t2", 32'(dut.g_ch[2].u_ch.timer_r),  32'(m_timer[2]));
        out_rdy = 1'b1;
        repeat (20) step_clk();

        // Mixer: all channels duty 3, period 8, restarted together under stall.
        out_rdy = 1'b0;
        cfg_write(0, 8, 3, 1'b1, 15);
        cfg_write(1, 8, 3, 1'b1, 7);
        cfg_write(2, 8, 3, 1'b1, 1);
        out_rdy = 1'b1;
        step_clk();
        chk("mix_all", 32'(out_mix), 32'(MIX_ALL));
        repeat (30) step_clk();

        // Asynchronous reset mid-operation clears outputs without a clock.
        rst_n = 1'b0;
        #1;
        chk("arst_out_vld",  32'(out_vld),  32'd0);
        chk("arst_cfg_rdy",  32'(cfg_rdy),  32'd0);
        chk("arst_out_bits", 32'(out_bits), 32'd0);
        chk("arst_out_mix",  32'(out_mix),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
